// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   CLA_GRP_W : width of one lookahead group (bits)
//   cla_ngrp  : number of groups needed for a given operand width
//   cla_gp_t  : group generate/propagate pair
package cla_pkg;

  localparam int unsigned CLA_GRP_W = 4;

  typedef struct packed {
    logic g;
    logic p;
  } cla_gp_t;

  function automatic int unsigned cla_ngrp(input int unsigned width);
    return width / CLA_GRP_W;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group (purely combinational).
// Ports:
//   g, p    : per-bit generate (a&b) and propagate (a|b)
//   cin_grp : carry into bit 0 of the group
//   c       : carry into each bit of the group, c[0] = cin_grp
//   gp      : group generate/propagate, independent of cin_grp
module cla_group4
  import cla_pkg::*;
(
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin_grp,
  output logic [3:0] c,
  output cla_gp_t    gp
);

  assign c[0] = cin_grp;
  assign c[1] = g[0] | (p[0] & cin_grp);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_grp);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_grp);

  assign gp.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign gp.p = &p;

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready streaming.
// Stage 1 registers bit terms and per-group G/P; stage 2 resolves the group carry chain,
// in-group carries, sum, carry-out and signed overflow.
// Ports:
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready combinationally follows out_ready)
//   in_a, in_b, in_cin    : operands and carry-in
//   in_sub                : only with CLA_ADDER_SUB_EN defined; computes a - b (+ cin inverted)
//   out_valid / out_ready : result handshake; outputs hold while stalled
//   out_sum, out_cout     : sum modulo 2^WIDTH and carry out of the MSB
//   out_ovf               : signed overflow (carry into MSB xor carry out of MSB)
// Macro CLA_ADDER_SUB_EN enables the optional subtract control.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NGRP  = cla_ngrp(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CLA_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  if ((WIDTH % CLA_GRP_W) != 0 || WIDTH < CLA_GRP_W) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a multiple of 4 and at least 4");
  end
  if (NGRP != cla_ngrp(WIDTH)) begin : g_bad_ngrp
    $error("cla_adder_pipe: NGRP is derived from WIDTH and must not be overridden");
  end

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_en, s2_en;

  always_comb begin
    s2_en      = !s2_valid_q || out_ready;
    s1_en      = !s1_valid_q || s2_en;
    s1_valid_d = s1_en ? in_valid : s1_valid_q;
    s2_valid_d = s2_en ? s1_valid_q : s2_valid_q;
  end

  assign in_ready = s1_en;

  // ---------------------------------------------------------------------------
  // Stage 1: bit terms and group generate/propagate
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef CLA_ADDER_SUB_EN
  assign b_eff   = in_b ^ {WIDTH{in_sub}};
  assign cin_eff = in_cin ^ in_sub;
`else
  assign b_eff   = in_b;
  assign cin_eff = in_cin;
`endif

  logic [WIDTH-1:0] x_d, g_d, p_d;
  assign x_d = in_a ^ b_eff;
  assign g_d = in_a & b_eff;
  assign p_d = in_a | b_eff;

  cla_gp_t [NGRP-1:0] grp_gp_d;
  // In-group carries are not needed until stage 2; G/P do not depend on cin_grp.
  logic [WIDTH-1:0]   unused_s1_c;

  for (genvar k = 0; k < NGRP; k++) begin : g_s1_grp
    cla_group4 u_grp (
      .g       (g_d[CLA_GRP_W*k +: CLA_GRP_W]),
      .p       (p_d[CLA_GRP_W*k +: CLA_GRP_W]),
      .cin_grp (1'b0),
      .c       (unused_s1_c[CLA_GRP_W*k +: CLA_GRP_W]),
      .gp      (grp_gp_d[k])
    );
  end

  logic [WIDTH-1:0]   s1_x_q, s1_g_q, s1_p_q;
  cla_gp_t [NGRP-1:0] s1_gp_q;
  logic               s1_cin_q;

  // Data registers load whenever the stage may advance; validity is tracked separately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_g_q     <= '0;
      s1_p_q     <= '0;
      s1_gp_q    <= '0;
      s1_cin_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_en) begin
        s1_x_q   <= x_d;
        s1_g_q   <= g_d;
        s1_p_q   <= p_d;
        s1_gp_q  <= grp_gp_d;
        s1_cin_q <= cin_eff;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: group carry chain, in-group carries, sum and flags
  // ---------------------------------------------------------------------------
  logic [NGRP:0] grp_c;

  always_comb begin
    grp_c    = '0;
    grp_c[0] = s1_cin_q;
    for (int unsigned k = 0; k < NGRP; k++) begin
      grp_c[k+1] = s1_gp_q[k].g | (s1_gp_q[k].p & grp_c[k]);
    end
  end

  logic [WIDTH-1:0]   bit_c;
  cla_gp_t [NGRP-1:0] unused_s2_gp;

  for (genvar k = 0; k < NGRP; k++) begin : g_s2_grp
    cla_group4 u_grp (
      .g       (s1_g_q[CLA_GRP_W*k +: CLA_GRP_W]),
      .p       (s1_p_q[CLA_GRP_W*k +: CLA_GRP_W]),
      .cin_grp (grp_c[k]),
      .c       (bit_c[CLA_GRP_W*k +: CLA_GRP_W]),
      .gp      (unused_s2_gp[k])
    );
  end

  logic [WIDTH-1:0] sum_d;
  logic             cout_d, ovf_d;

  assign sum_d  = s1_x_q ^ bit_c;
  assign cout_d = grp_c[NGRP];
  assign ovf_d  = bit_c[WIDTH-1] ^ grp_c[NGRP];

  logic [WIDTH-1:0] s2_sum_q;
  logic             s2_cout_q, s2_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_cout_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_en) begin
        s2_sum_q  <= sum_d;
        s2_cout_q <= cout_d;
        s2_ovf_q  <= ovf_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_cout  = s2_cout_q;
  assign out_ovf   = s2_ovf_q;

endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder built from 4-bit lookahead groups with a second-level group lookahead.
- Generalises the fixed 4-bit carry generator to any WIDTH that is a multiple of 4.
- Adds a valid/ready stream handshake with backpressure, a registered carry-out and signed overflow.
- Sits in the adder library as the throughput-oriented adder for datapaths that need full-rate streaming.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4. Any other value is an elaboration error.
- NGRP, WIDTH/4, number of 4-bit groups. Derived; not to be overridden.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operands valid
- in_ready  out  1  adder can accept an operand set this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  WIDTH  sum bits
- out_cout  out  1  carry out of MSB
- out_ovf  out  1  signed overflow, i.e. carry into MSB XOR carry out of MSB

Behaviour:
- Reset (asynchronous, rst_n low): s1_valid=0, s2_valid=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0. All pipeline data registers clear to 0.
- Bit-level terms: g[i]=a[i]&b[i], p[i]=a[i]|b[i]. The sum bit uses the XOR term a[i]^b[i].
- Stage 1 (registered):
  - Computes per-group generate G[k]=g3|p3g2|p3p2g1|p3p2p1g0 and propagate P[k]=p3&p2&p1&p0.
  - Carry-in of every group's term includes the full propagate chain.
  - Registers a^b, g, p, G, P and cin.
- Stage 2 (registered):
  - Computes group carries C[k+1]=G[k]|(P[k]&C[k]) with C[0]=cin.
  - Derives in-group carries with 4-bit lookahead.
  - sum[i] = x[i]^c[i].
  - out_cout = C[NGRP].
  - out_ovf = c[WIDTH-1]^C[NGRP].
- Latency: exactly 2 clk cycles from input acceptance to out_valid with no backpressure. Throughput is one result per cycle.
- Handshake:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - Stage enables: s2_en = !s2_valid | out_ready; s1_en = !s1_valid | s2_en.
  - in_ready = s1_en. This is a combinational path from out_ready; it is accepted.
  - While out_valid=1 and out_ready=0, out_sum, out_cout and out_ovf hold stable.
  - in_valid must not depend on in_ready.
- Simultaneous accept and emit with the pipeline full and out_ready=1: the pipeline advances, no bubble, no data lost.
- Empty pipeline with in_valid=0: valid bits stay 0. Data registers may update freely.
- Wrap-around: the sum is modulo 2^WIDTH. The carry appears only on out_cout.
- Reset mid-operation: in-flight results are discarded and out_valid drops asynchronously. After release, the first accepted input appears 2 cycles later.

Optional Feature:
- Macro: CLA_ADDER_SUB_EN.
- Defined:
  - Adds port in_sub (in, 1), captured with the operands.
  - Effective b = in_b ^ {WIDTH{in_sub}}; effective cin = in_cin ^ in_sub.
  - With in_cin=0, in_sub=1 computes A-B.
  - out_cout is the raw carry, i.e. 1 means no borrow.
  - out_ovf is signed overflow of the subtraction.
- Not defined: the port is absent and the block is a pure adder.

Decomposition:
- Shared package cla_pkg:
  - localparam CLA_GRP_W=4.
  - function cla_ngrp(width) returning width/CLA_GRP_W.
  - typedef cla_gp_t, a struct {g, p} used for group outputs.
- One natural sub-module, cla_group4 (combinational):
  - Inputs: 4-bit g, p and cin_grp.
  - Outputs: 4 internal carries plus group G and P.
  - Instantiated NGRP times in generate loops for stage 1 (G/P) and stage 2 (carries).
  - The second-level group chain is written in the top level.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=0, out_ready=1 -> out_sum=0x5555, cout=0, ovf=0 exactly 2 cycles after acceptance.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Both exercise the full propagate chain.
- Back-to-back stream of 8 random pairs with out_ready=1 throughout -> 8 consecutive out_valid cycles, results in order, in_ready constantly 1.
- Pipeline full, out_ready held 0 for 5 cycles -> in_ready=0 after 2 accepts, outputs stable, nothing lost. On release, results drain in order.
- rst_n pulsed low while 2 results are in flight -> out_valid=0 immediately. After release, only new inputs emerge.
- CLA_ADDER_SUB_EN defined, in_sub=1, a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0. Repeat at WIDTH=32 and WIDTH=4 with random vectors checked against a behavioural a+b+cin model.
